led_output_ahb: RTL and testbench

AHB-Lite zero-wait-state slave driving the board's 15 LEDs, the output-direction companion of the switch input peripheral on the same bus. Firmware writes an LED pattern, per-LED blink enables and a blink divider; the block holds the state in registers and drives a registered LED bus with a free-running blink phase. All registers read back over HRDATA.

---
 rtl/led_output_ahb_if.sv | 23 ++
 rtl/led_output_ahb.sv | 116 +++++++++++
 tb/tb_led_output_ahb.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_output_ahb_if.sv
// rtl/led_output_ahb_if.sv - AHB-Lite slave bus bundle for the LED output peripheral
interface led_output_ahb_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/led_output_ahb.sv
// rtl/led_output_ahb.sv - AHB-Lite zero-wait LED output slave with per-LED blink
module led_output_ahb #(
  parameter int          LED_WIDTH = 15,
  parameter logic [15:0] DIV_RESET = 16'hFFFF
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  led_output_ahb_if.slave      bus,
  output logic [LED_WIDTH-1:0] LED
);

  localparam logic [1:0] A_LED_DATA  = 2'd0;
  localparam logic [1:0] A_BLINK_EN  = 2'd1;
  localparam logic [1:0] A_BLINK_DIV = 2'd2;
  localparam logic [1:0] A_TOGGLE    = 2'd3;

  // data-phase state latched from the address phase
  logic       r_dp_write;
  logic       r_dp_read;
  logic [1:0] r_dp_addr;
  logic       r_dp_mapped;

  logic [LED_WIDTH-1:0] r_led_data;
  logic [LED_WIDTH-1:0] r_blink_en;
  logic [15:0]          r_blink_div;
  logic [15:0]          r_cnt;
  logic                 r_phase;

  logic w_valid;
  logic w_wr;
  logic w_div_wr;
  logic w_unused;

  assign w_valid  = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign w_wr     = r_dp_write & r_dp_mapped;
  assign w_div_wr = w_wr & (r_dp_addr == A_BLINK_DIV);

  // HSIZE and the address/data bits outside the register map carry no meaning here
  assign w_unused = ^{bus.HSIZE, bus.HADDR[31:12], bus.HADDR[1:0], bus.HWDATA[31:16]};

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  // capture an accepted address phase; idle cycles clear the pending access
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dp_write  <= 1'b0;
      r_dp_read   <= 1'b0;
      r_dp_addr   <= 2'd0;
      r_dp_mapped <= 1'b0;
    end else if (w_valid) begin
      r_dp_write  <= bus.HWRITE;
      r_dp_read   <= ~bus.HWRITE;
      r_dp_addr   <= bus.HADDR[3:2];
      r_dp_mapped <= (bus.HADDR[11:4] == 8'd0);
    end else begin
      r_dp_write  <= 1'b0;
      r_dp_read   <= 1'b0;
    end
  end

  // register file update at the end of a write data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_led_data  <= '0;
      r_blink_en  <= '0;
      r_blink_div <= DIV_RESET;
    end else if (w_wr) begin
      case (r_dp_addr)
        A_LED_DATA:  r_led_data  <= bus.HWDATA[LED_WIDTH-1:0];
        A_BLINK_EN:  r_blink_en  <= bus.HWDATA[LED_WIDTH-1:0];
        A_BLINK_DIV: r_blink_div <= bus.HWDATA[15:0];
        A_TOGGLE:    r_led_data  <= r_led_data ^ bus.HWDATA[LED_WIDTH-1:0];
        default:     ;
      endcase
    end
  end

  // blink divider; reprogramming the divider restarts the count but keeps the phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_cnt   <= 16'd0;
      r_phase <= 1'b0;
    end else if (w_div_wr) begin
      r_cnt   <= 16'd0;
    end else if (r_cnt == r_blink_div) begin
      r_cnt   <= 16'd0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 16'd1;
    end
  end

  // registered LED drive from the pre-edge register values
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      LED <= '0;
    end else begin
      LED <= r_led_data & (~r_blink_en | {LED_WIDTH{r_phase}});
    end
  end

  // read mux; unmapped, toggle and idle data phases return zero
  always_comb begin
    bus.HRDATA = 32'd0;
    if (r_dp_read && r_dp_mapped) begin
      case (r_dp_addr)
        A_LED_DATA:  bus.HRDATA = {{(32-LED_WIDTH){1'b0}}, r_led_data};
        A_BLINK_EN:  bus.HRDATA = {{(32-LED_WIDTH){1'b0}}, r_blink_en};
        A_BLINK_DIV: bus.HRDATA = {16'd0, r_blink_div};
        default:     bus.HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_output_ahb.sv
// tb/tb_led_output_ahb.sv - directed self-checking bench for led_output_ahb
module tb_led_output_ahb;
  logic        HCLK;
  logic        HRESET;
  logic [14:0] led;
  int          n_vec;
  int          n_err;

  led_output_ahb_if bus();

  led_output_ahb #(.LED_WIDTH(15), .DIV_RESET(16'hFFFF)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus),
    .LED    (led)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_ph(input logic wr, input logic [31:0] a);
    bus.HSEL   = 1'b1;
    bus.HREADY = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
    bus.HADDR  = a;
  endtask

  task automatic idle;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'd0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr_ph(1'b1, a);
    tick;
    idle;
    bus.HWDATA = d;
    tick;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    addr_ph(1'b0, a);
    tick;
    idle;
    d = bus.HRDATA;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    HRESET = 1'b1;
    tick;
    tick;
    HRESET = 1'b0;
    n_vec++; if (led !== 15'h0) begin n_err++; $display("FAIL reset_led got %h want %h", led, 15'h0); end
    n_vec++; if (bus.HRDATA !== 32'h0) begin n_err++; $display("FAIL reset_hrdata got %h want %h", bus.HRDATA, 32'h0); end
    n_vec++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin n_err++; $display("FAIL reset_resp got %b%b want 10", bus.HREADYOUT, bus.HRESP); end
    do_read(32'h8, d);
    n_vec++; if (d !== 32'h0000FFFF) begin n_err++; $display("FAIL reset_div got %h want %h", d, 32'h0000FFFF); end
    do_read(32'h0, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want %h", d, 32'h0); end
  endtask

  task automatic test_write_read;
    addr_ph(1'b1, 32'h0);
    tick;
    bus.HWDATA = 32'h11;
    addr_ph(1'b0, 32'h0);
    tick;
    idle;
    n_vec++; if (bus.HRDATA !== 32'h11) begin n_err++; $display("FAIL wr_rd_data got %h want %h", bus.HRDATA, 32'h11); end
    n_vec++; if (led !== 15'h0) begin n_err++; $display("FAIL wr_led_early got %h want %h", led, 15'h0); end
    tick;
    n_vec++; if (led !== 15'h0011) begin n_err++; $display("FAIL wr_led got %h want %h", led, 15'h0011); end
  endtask

  task automatic test_toggle;
    logic [31:0] d;
    do_write(32'hC, 32'h20);
    do_read(32'h0, d);
    n_vec++; if (d !== 32'h31) begin n_err++; $display("FAIL toggle_set got %h want %h", d, 32'h31); end
    tick;
    n_vec++; if (led !== 15'h0031) begin n_err++; $display("FAIL toggle_led got %h want %h", led, 15'h0031); end
    do_write(32'hC, 32'h20);
    do_read(32'h0, d);
    n_vec++; if (d !== 32'h11) begin n_err++; $display("FAIL toggle_clr got %h want %h", d, 32'h11); end
    do_read(32'hC, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL toggle_read got %h want %h", d, 32'h0); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    addr_ph(1'b1, 32'h0);
    tick;
    bus.HWDATA = 32'h1;
    addr_ph(1'b1, 32'h0);
    tick;
    bus.HWDATA = 32'h2;
    addr_ph(1'b1, 32'h4);
    tick;
    bus.HWDATA = 32'h3;
    idle;
    tick;
    do_read(32'h0, d);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL b2b_last got %h want %h", d, 32'h2); end
    do_read(32'h4, d);
    n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL b2b_en got %h want %h", d, 32'h3); end
    do_write(32'h4, 32'h0);
    do_write(32'h0, 32'h11);
  endtask

  task automatic test_ignored;
    logic [31:0] d;
    addr_ph(1'b1, 32'h0);
    bus.HREADY = 1'b0;
    tick;
    idle;
    bus.HREADY = 1'b1;
    bus.HWDATA = 32'h7FFF;
    tick;
    do_read(32'h0, d);
    n_vec++; if (d !== 32'h11) begin n_err++; $display("FAIL hready_low got %h want %h", d, 32'h11); end
    addr_ph(1'b1, 32'h0);
    bus.HTRANS = 2'b00;
    tick;
    idle;
    bus.HWDATA = 32'h7FFF;
    tick;
    do_read(32'h0, d);
    n_vec++; if (d !== 32'h11) begin n_err++; $display("FAIL htrans_idle got %h want %h", d, 32'h11); end
    do_write(32'h10, 32'h7FFF);
    do_read(32'h0, d);
    n_vec++; if (d !== 32'h11) begin n_err++; $display("FAIL unmapped_wr got %h want %h", d, 32'h11); end
    do_read(32'h10, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_rd got %h want %h", d, 32'h0); end
  endtask

  task automatic test_widths;
    logic [31:0] d;
    do_write(32'h4, 32'hFFFFFFFF);
    do_read(32'h4, d);
    n_vec++; if (d !== 32'h7FFF) begin n_err++; $display("FAIL width_en got %h want %h", d, 32'h7FFF); end
    do_write(32'h8, 32'hFFFF1234);
    do_read(32'h8, d);
    n_vec++; if (d !== 32'h1234) begin n_err++; $display("FAIL width_div got %h want %h", d, 32'h1234); end
    do_write(32'h0, 32'hFFFF8011);
    do_read(32'h0, d);
    n_vec++; if (d !== 32'h11) begin n_err++; $display("FAIL width_data got %h want %h", d, 32'h11); end
    do_write(32'h4, 32'h0);
  endtask

  task automatic test_blink;
    logic prev;
    int   last;
    int   nch;
    int   bad4;
    do_write(32'h4, 32'h1);
    do_write(32'h8, 32'h3);
    prev = led[0];
    last = -1;
    nch  = 0;
    bad4 = 0;
    for (int i = 0; i < 26; i++) begin
      tick;
      if (led[4] !== 1'b1) bad4++;
      if (led[0] !== prev) begin
        if (last >= 0) begin
          n_vec++; if (i - last != 4) begin n_err++; $display("FAIL blink_period got %0d want %0d", i - last, 4); end
        end
        last = i;
        nch++;
        prev = led[0];
      end
    end
    n_vec++; if (nch < 5) begin n_err++; $display("FAIL blink_count got %0d want >= %0d", nch, 5); end
    n_vec++; if (bad4 != 0) begin n_err++; $display("FAIL blink_steady got %0d bad want %0d", bad4, 0); end
    do_write(32'h8, 32'h0);
    tick;
    tick;
    prev = led[0];
    bad4 = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (led[0] === prev) bad4++;
      if (led[4] !== 1'b1) bad4++;
      prev = led[0];
    end
    n_vec++; if (bad4 != 0) begin n_err++; $display("FAIL blink_fast got %0d bad want %0d", bad4, 0); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    do_write(32'h4, 32'h7);
    do_write(32'h8, 32'h5);
    addr_ph(1'b1, 32'h0);
    tick;
    idle;
    bus.HWDATA = 32'h5555;
    HRESET = 1'b1;
    tick;
    HRESET = 1'b0;
    n_vec++; if (led !== 15'h0) begin n_err++; $display("FAIL rst_mid_led got %h want %h", led, 15'h0); end
    n_vec++; if (bus.HRDATA !== 32'h0) begin n_err++; $display("FAIL rst_mid_hrdata got %h want %h", bus.HRDATA, 32'h0); end
    do_read(32'h0, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_mid_data got %h want %h", d, 32'h0); end
    do_read(32'h4, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_mid_en got %h want %h", d, 32'h0); end
    do_read(32'h8, d);
    n_vec++; if (d !== 32'hFFFF) begin n_err++; $display("FAIL rst_mid_div got %h want %h", d, 32'hFFFF); end
    tick;
    n_vec++; if (led !== 15'h0) begin n_err++; $display("FAIL rst_mid_led2 got %h want %h", led, 15'h0); end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    HRESET     = 1'b1;
    bus.HREADY = 1'b1;
    bus.HSIZE  = 3'b010;
    bus.HWDATA = 32'd0;
    idle;
    test_reset;
    test_write_read;
    test_toggle;
    test_back_to_back;
    test_ignored;
    test_widths;
    test_blink;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
